// File: rtl/control_unit.sv
// Hardwired control sequencer for the single-bus datapath: T0-T2 fetch, then
// opcode-driven execute steps T3-T7, with Moore-decoded control strobes.
module control_unit #(
   parameter logic [4:0] OP_ADD = 5'b00011
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        con_out,
   output logic        pc_out,
   output logic        zlo_out,
   output logic        zhi_out,
   output logic        hi_out,
   output logic        lo_out,
   output logic        mdr_out,
   output logic        inport_out,
   output logic        c_sign_extended_out,
   output logic        ba_out,
   output logic        r_out,
   output logic        pc_enable,
   output logic        pc_increment,
   output logic        mar_enable,
   output logic        mdr_enable,
   output logic        read,
   output logic        ir_enable,
   output logic        y_enable,
   output logic        z_enable,
   output logic        hi_enable,
   output logic        lo_enable,
   output logic        r_in,
   output logic        con_enable,
   output logic        outport_enable,
   output logic        inport_enable,
   output logic        r15_enable,
   output logic        ram_write,
   output logic        gra,
   output logic        grb,
   output logic        grc,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic        instr_done,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OPC_LD   = 5'b00000;
   localparam logic [4:0] OPC_LDI  = 5'b00001;
   localparam logic [4:0] OPC_ST   = 5'b00010;
   localparam logic [4:0] OPC_ADD  = 5'b00011;
   localparam logic [4:0] OPC_SUB  = 5'b00100;
   localparam logic [4:0] OPC_AND  = 5'b00101;
   localparam logic [4:0] OPC_OR   = 5'b00110;
   localparam logic [4:0] OPC_ADDI = 5'b01100;
   localparam logic [4:0] OPC_BR   = 5'b10011;
   localparam logic [4:0] OPC_JR   = 5'b10100;
   localparam logic [4:0] OPC_IN   = 5'b10110;
   localparam logic [4:0] OPC_OUT  = 5'b10111;
   localparam logic [4:0] OPC_MFHI = 5'b11000;
   localparam logic [4:0] OPC_MFLO = 5'b11001;
   localparam logic [4:0] OPC_NOP  = 5'b11010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

   state_t     r_state;
   state_t     w_next;
   logic [4:0] w_opcode;
   logic       w_last;
   logic       w_unused_ir;

   assign w_opcode    = ir[31:27];
   assign w_unused_ir = ^ir[26:0];

   // Final execute step of the current instruction; never set during fetch.
   always_comb begin
      w_last = 1'b0;
      case (r_state)
         S_T3: begin
            case (w_opcode)
               OPC_LD, OPC_LDI, OPC_ST, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
               OPC_ADDI, OPC_BR: w_last = 1'b0;
               default:          w_last = 1'b1;
            endcase
         end
         S_T5: begin
            case (w_opcode)
               OPC_LDI, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: w_last = 1'b1;
               default: w_last = 1'b0;
            endcase
         end
         S_T6:    w_last = (w_opcode == OPC_BR);
         S_T7:    w_last = 1'b1;
         default: w_last = 1'b0;
      endcase
   end

   always_comb begin
      w_next = S_RESET;
      case (r_state)
         S_RESET: w_next = S_T0;
         S_T0:    w_next = S_T1;
         S_T1:    w_next = S_T2;
         S_T2:    w_next = S_T3;
         S_T3: begin
            if (w_opcode == OPC_HALT) w_next = S_HALT;
            else if (w_last)          w_next = S_T0;
            else                      w_next = S_T4;
         end
         S_T4:    w_next = S_T5;
         S_T5:    w_next = w_last ? S_T0 : S_T6;
         S_T6:    w_next = w_last ? S_T0 : S_T7;
         S_T7:    w_next = S_T0;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= S_RESET;
      else      r_state <= w_next;
   end

   assign zhi_out       = 1'b0;
   assign hi_enable     = 1'b0;
   assign lo_enable     = 1'b0;
   assign inport_enable = 1'b0;
   assign r15_enable    = 1'b0;

   always_comb begin
      pc_out              = 1'b0;
      zlo_out             = 1'b0;
      hi_out              = 1'b0;
      lo_out              = 1'b0;
      mdr_out             = 1'b0;
      inport_out          = 1'b0;
      c_sign_extended_out = 1'b0;
      ba_out              = 1'b0;
      r_out               = 1'b0;
      pc_enable           = 1'b0;
      pc_increment        = 1'b0;
      mar_enable          = 1'b0;
      mdr_enable          = 1'b0;
      read                = 1'b0;
      ir_enable           = 1'b0;
      y_enable            = 1'b0;
      z_enable            = 1'b0;
      r_in                = 1'b0;
      con_enable          = 1'b0;
      outport_enable      = 1'b0;
      ram_write           = 1'b0;
      gra                 = 1'b0;
      grb                 = 1'b0;
      grc                 = 1'b0;
      alu_op              = '0;
      illegal             = 1'b0;
      run                 = (r_state != S_RESET) && (r_state != S_HALT);
      instr_done          = w_last;

      case (r_state)
         S_T0: begin
            pc_out       = 1'b1;
            mar_enable   = 1'b1;
            pc_increment = 1'b1;
            z_enable     = 1'b1;
         end
         S_T1: begin
            zlo_out    = 1'b1;
            pc_enable  = 1'b1;
            read       = 1'b1;
            mdr_enable = 1'b1;
         end
         S_T2: begin
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
         end
         S_T3: begin
            case (w_opcode)
               OPC_LD, OPC_LDI, OPC_ST: begin
                  grb      = 1'b1;
                  ba_out   = 1'b1;
                  y_enable = 1'b1;
               end
               OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: begin
                  grb      = 1'b1;
                  r_out    = 1'b1;
                  y_enable = 1'b1;
               end
               OPC_BR: begin
                  gra        = 1'b1;
                  r_out      = 1'b1;
                  con_enable = 1'b1;
               end
               OPC_JR: begin
                  gra       = 1'b1;
                  r_out     = 1'b1;
                  pc_enable = 1'b1;
               end
               OPC_IN: begin
                  inport_out = 1'b1;
                  gra        = 1'b1;
                  r_in       = 1'b1;
               end
               OPC_OUT: begin
                  gra            = 1'b1;
                  r_out          = 1'b1;
                  outport_enable = 1'b1;
               end
               OPC_MFHI: begin
                  hi_out = 1'b1;
                  gra    = 1'b1;
                  r_in   = 1'b1;
               end
               OPC_MFLO: begin
                  lo_out = 1'b1;
                  gra    = 1'b1;
                  r_in   = 1'b1;
               end
               OPC_NOP, OPC_HALT: ;
               default: illegal = 1'b1;
            endcase
         end
         S_T4: begin
            case (w_opcode)
               OPC_LD, OPC_LDI, OPC_ST, OPC_ADDI: begin
                  c_sign_extended_out = 1'b1;
                  z_enable            = 1'b1;
                  alu_op              = OP_ADD;
               end
               OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
                  grc      = 1'b1;
                  r_out    = 1'b1;
                  z_enable = 1'b1;
                  alu_op   = w_opcode;
               end
               OPC_BR: begin
                  pc_out   = 1'b1;
                  y_enable = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (w_opcode)
               OPC_LD, OPC_ST: begin
                  zlo_out    = 1'b1;
                  mar_enable = 1'b1;
               end
               OPC_LDI, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI: begin
                  zlo_out = 1'b1;
                  gra     = 1'b1;
                  r_in    = 1'b1;
               end
               OPC_BR: begin
                  c_sign_extended_out = 1'b1;
                  z_enable            = 1'b1;
                  alu_op              = OP_ADD;
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (w_opcode)
               OPC_LD: begin
                  read       = 1'b1;
                  mdr_enable = 1'b1;
               end
               OPC_ST: begin
                  gra        = 1'b1;
                  r_out      = 1'b1;
                  mdr_enable = 1'b1;
               end
               OPC_BR: begin
                  zlo_out   = con_out;
                  pc_enable = con_out;
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (w_opcode)
               OPC_LD: begin
                  mdr_out = 1'b1;
                  gra     = 1'b1;
                  r_in    = 1'b1;
               end
               OPC_ST: ram_write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: steps instructions cycle by cycle and
// compares the packed strobe word against hand-built per-step masks.
module tb_control_unit;

   logic        clk;
   logic        clr;
   logic [31:0] ir;
   logic        con_out;
   logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out;
   logic c_sign_extended_out, ba_out, r_out, pc_enable, pc_increment;
   logic mar_enable, mdr_enable, read, ir_enable, y_enable, z_enable;
   logic hi_enable, lo_enable, r_in, con_enable, outport_enable;
   logic inport_enable, r15_enable, ram_write, gra, grb, grc;
   logic [4:0] alu_op;
   logic run, instr_done, illegal;

   int n_tests = 0;
   int n_fail  = 0;

   control_unit #(.OP_ADD(5'b00011)) dut (
      .clk(clk), .clr(clr), .ir(ir), .con_out(con_out),
      .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
      .hi_out(hi_out), .lo_out(lo_out), .mdr_out(mdr_out),
      .inport_out(inport_out), .c_sign_extended_out(c_sign_extended_out),
      .ba_out(ba_out), .r_out(r_out), .pc_enable(pc_enable),
      .pc_increment(pc_increment), .mar_enable(mar_enable),
      .mdr_enable(mdr_enable), .read(read), .ir_enable(ir_enable),
      .y_enable(y_enable), .z_enable(z_enable), .hi_enable(hi_enable),
      .lo_enable(lo_enable), .r_in(r_in), .con_enable(con_enable),
      .outport_enable(outport_enable), .inport_enable(inport_enable),
      .r15_enable(r15_enable), .ram_write(ram_write),
      .gra(gra), .grb(grb), .grc(grc), .alu_op(alu_op),
      .run(run), .instr_done(instr_done), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] w_strobes;
   assign w_strobes = {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out,
                       inport_out, c_sign_extended_out, ba_out, r_out,
                       pc_enable, pc_increment, mar_enable, mdr_enable, read,
                       ir_enable, y_enable, z_enable, hi_enable, lo_enable,
                       r_in, con_enable, outport_enable, inport_enable,
                       r15_enable, ram_write, gra, grb, grc, run, instr_done,
                       illegal};

   localparam logic [31:0] PC_OUT  = 32'd1 << 31;
   localparam logic [31:0] ZLO     = 32'd1 << 30;
   localparam logic [31:0] MDR_OUT = 32'd1 << 26;
   localparam logic [31:0] IN_OUT  = 32'd1 << 25;
   localparam logic [31:0] CSE     = 32'd1 << 24;
   localparam logic [31:0] BA_OUT  = 32'd1 << 23;
   localparam logic [31:0] R_OUT   = 32'd1 << 22;
   localparam logic [31:0] PC_EN   = 32'd1 << 21;
   localparam logic [31:0] PC_INC  = 32'd1 << 20;
   localparam logic [31:0] MAR_EN  = 32'd1 << 19;
   localparam logic [31:0] MDR_EN  = 32'd1 << 18;
   localparam logic [31:0] READ    = 32'd1 << 17;
   localparam logic [31:0] IR_EN   = 32'd1 << 16;
   localparam logic [31:0] Y_EN    = 32'd1 << 15;
   localparam logic [31:0] Z_EN    = 32'd1 << 14;
   localparam logic [31:0] R_IN    = 32'd1 << 11;
   localparam logic [31:0] CON_EN  = 32'd1 << 10;
   localparam logic [31:0] OUT_EN  = 32'd1 << 9;
   localparam logic [31:0] RAM_WR  = 32'd1 << 6;
   localparam logic [31:0] GRA     = 32'd1 << 5;
   localparam logic [31:0] GRB     = 32'd1 << 4;
   localparam logic [31:0] RUN     = 32'd1 << 2;
   localparam logic [31:0] DONE    = 32'd1 << 1;
   localparam logic [31:0] ILL     = 32'd1 << 0;

   localparam logic [31:0] F0 = RUN | PC_OUT | MAR_EN | PC_INC | Z_EN;
   localparam logic [31:0] F1 = RUN | ZLO | PC_EN | READ | MDR_EN;
   localparam logic [31:0] F2 = RUN | MDR_OUT | IR_EN;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Caller sits at a falling edge; checks this step then advances one cycle.
   task automatic step(input string tag, input logic [31:0] exp);
      check(tag, w_strobes, exp);
      @(negedge clk);
   endtask

   task automatic fetch(input string tag);
      step({tag, "_T0"}, F0);
      step({tag, "_T1"}, F1);
      step({tag, "_T2"}, F2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      clr     = 1'b0;
      con_out = 1'b0;
      ir      = 32'h0080_0004;
      @(negedge clk);
      check("por_reset", w_strobes, 32'd0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);

      // ld, interrupted by reset during T5
      fetch("ld");
      step("ld_T3", RUN | GRB | BA_OUT | Y_EN);
      check("ld_T4_alu", {27'd0, alu_op}, 32'd3);
      step("ld_T4", RUN | CSE | Z_EN);
      check("ld_T5", w_strobes, RUN | ZLO | MAR_EN);
      clr = 1'b0;
      #1;
      check("ld_abort_async", w_strobes, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ld_abort_hold", w_strobes, 32'd0);
      end
      clr = 1'b1;
      @(negedge clk);

      ir = 32'h0880_0005;
      fetch("ldi");
      step("ldi_T3", RUN | GRB | BA_OUT | Y_EN);
      check("ldi_T4_alu", {27'd0, alu_op}, 32'd3);
      step("ldi_T4", RUN | CSE | Z_EN);
      step("ldi_T5", RUN | ZLO | GRA | R_IN | DONE);

      ir = 32'h1080_0010;
      fetch("st");
      step("st_T3", RUN | GRB | BA_OUT | Y_EN);
      step("st_T4", RUN | CSE | Z_EN);
      step("st_T5", RUN | ZLO | MAR_EN);
      step("st_T6", RUN | GRA | R_OUT | MDR_EN);
      step("st_T7", RUN | RAM_WR | DONE);

      ir      = 32'h9980_0009;
      con_out = 1'b1;
      fetch("br1");
      step("br1_T3", RUN | GRA | R_OUT | CON_EN);
      step("br1_T4", RUN | PC_OUT | Y_EN);
      check("br1_T5_alu", {27'd0, alu_op}, 32'd3);
      step("br1_T5", RUN | CSE | Z_EN);
      step("br1_T6", RUN | ZLO | PC_EN | DONE);

      con_out = 1'b0;
      fetch("br0");
      step("br0_T3", RUN | GRA | R_OUT | CON_EN);
      step("br0_T4", RUN | PC_OUT | Y_EN);
      step("br0_T5", RUN | CSE | Z_EN);
      step("br0_T6", RUN | DONE);

      ir = 32'h2000_0000;
      fetch("sub");
      step("sub_T3", RUN | GRB | R_OUT | Y_EN);
      check("sub_T4_alu", {27'd0, alu_op}, 32'd4);
      step("sub_T4", RUN | (32'd1 << 3) | R_OUT | Z_EN);
      step("sub_T5", RUN | ZLO | GRA | R_IN | DONE);

      ir = 32'hBB00_0000;
      fetch("out");
      step("out_T3", RUN | GRA | R_OUT | OUT_EN | DONE);

      ir = 32'hF800_0000;
      fetch("ill");
      step("ill_T3", RUN | ILL | DONE);

      ir = 32'hB000_0000;
      fetch("in");
      step("in_T3", RUN | IN_OUT | GRA | R_IN | DONE);

      ir = 32'hD800_0000;
      fetch("halt");
      step("halt_T3", RUN | DONE);
      for (int i = 0; i < 20; i++) begin
         check("halt_idle", w_strobes, 32'd0);
         @(negedge clk);
      end
      clr = 1'b0;
      #1;
      check("halt_clr", w_strobes, 32'd0);
      @(negedge clk);
      clr = 1'b1;
      ir  = 32'hD000_0000;
      @(negedge clk);
      fetch("nop");
      step("nop_T3", RUN | DONE);
      check("nop_next_T0", w_strobes, F0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
